// File: rtl/av_io_decoder.sv
// Address decoder and response mux between the AV I/O bridge and its devices.
// A timeout ack completes any request to a device that never answers.
module av_io_decoder #(
  parameter int          NDEV   = 8,
  parameter int          DEVLSB = 16,
  parameter int          TOUT   = 255,
  parameter logic [31:0] ERRDAT = 32'hFFFF_FFFF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              s_cyc_i,
  input  logic              s_stb_i,
  input  logic              s_we_i,
  input  logic [3:0]        s_sel_i,
  input  logic [31:0]       s_adr_i,
  input  logic [31:0]       s_dat_i,
  output logic              s_ack_o,
  output logic              s_stall_o,
  output logic [31:0]       s_dat_o,
  output logic [NDEV-1:0]   cs_o,
  output logic              we_o,
  output logic [3:0]        sel_o,
  output logic [31:0]       adr_o,
  output logic [31:0]       dat_o,
  input  logic [NDEV-1:0]   ack_i,
  input  logic [32*NDEV-1:0] dat_i,
  output logic              tout_o,
  output logic [31:0]       tout_adr_o,
  input  logic              tout_clr_i
);

  localparam int IW = (NDEV > 1) ? $clog2(NDEV) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [15:0]     TOUT_LAST = 16'(TOUT - 1);
  localparam logic [NDEV-1:0] ONE_HOT   = {{(NDEV-1){1'b0}}, 1'b1};

  logic [1:0]    state;
  logic [15:0]   cnt;
  logic [IW-1:0] idx;
  logic [IW-1:0] req_idx;

  assign req_idx = s_adr_i[DEVLSB +: IW];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      s_ack_o    <= 1'b0;
      s_stall_o  <= 1'b0;
      s_dat_o    <= '0;
      cs_o       <= '0;
      we_o       <= 1'b0;
      sel_o      <= '0;
      adr_o      <= '0;
      dat_o      <= '0;
      tout_o     <= 1'b0;
      tout_adr_o <= '0;
    end else begin
      // A timeout later in this block overrides the clear (set wins).
      if (tout_clr_i)
        tout_o <= 1'b0;

      case (state)
        IDLE: begin
          if (s_cyc_i && s_stb_i) begin
            we_o      <= s_we_i;
            sel_o     <= s_sel_i;
            adr_o     <= s_adr_i;
            dat_o     <= s_dat_i;
            idx       <= req_idx;
            cs_o      <= ONE_HOT << req_idx;
            cnt       <= '0;
            state     <= WAIT;
            s_stall_o <= 1'b1;
          end
        end

        WAIT: begin
          cnt <= cnt + 16'd1;
          if (!s_cyc_i) begin
            cs_o      <= '0;
            we_o      <= 1'b0;
            sel_o     <= '0;
            state     <= IDLE;
            s_stall_o <= 1'b0;
          end else if (ack_i[idx]) begin
            s_dat_o <= we_o ? 32'd0 : dat_i[32*idx +: 32];
            s_ack_o <= 1'b1;
            cs_o    <= '0;
            we_o    <= 1'b0;
            sel_o   <= '0;
            state   <= DONE;
          end else if (cnt == TOUT_LAST) begin
            s_dat_o    <= we_o ? 32'd0 : ERRDAT;
            s_ack_o    <= 1'b1;
            tout_o     <= 1'b1;
            tout_adr_o <= adr_o;
            cs_o       <= '0;
            state      <= DONE;
          end
        end

        DONE: begin
          // Ack is held until the bridge withdraws its strobe.
          if (!s_stb_i) begin
            s_ack_o   <= 1'b0;
            s_dat_o   <= '0;
            state     <= IDLE;
            s_stall_o <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          s_ack_o   <= 1'b0;
          s_stall_o <= 1'b0;
          cs_o      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_av_io_decoder.sv
// Directed-vector bench for av_io_decoder (NDEV=8, DEVLSB=16, TOUT=16).
module tb_av_io_decoder;

  localparam int NDEV = 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              s_cyc_i, s_stb_i, s_we_i;
  logic [3:0]        s_sel_i;
  logic [31:0]       s_adr_i, s_dat_i;
  logic              s_ack_o, s_stall_o;
  logic [31:0]       s_dat_o;
  logic [NDEV-1:0]   cs_o;
  logic              we_o;
  logic [3:0]        sel_o;
  logic [31:0]       adr_o, dat_o;
  logic [NDEV-1:0]   ack_i;
  logic [32*NDEV-1:0] dat_i;
  logic              tout_o;
  logic [31:0]       tout_adr_o;
  logic              tout_clr_i;

  int compared = 0;
  int mismatched = 0;

  av_io_decoder #(.NDEV(NDEV), .DEVLSB(16), .TOUT(16), .ERRDAT(32'hFFFF_FFFF)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_sel_i(s_sel_i),
    .s_adr_i(s_adr_i), .s_dat_i(s_dat_i),
    .s_ack_o(s_ack_o), .s_stall_o(s_stall_o), .s_dat_o(s_dat_o),
    .cs_o(cs_o), .we_o(we_o), .sel_o(sel_o), .adr_o(adr_o), .dat_o(dat_o),
    .ack_i(ack_i), .dat_i(dat_i),
    .tout_o(tout_o), .tout_adr_o(tout_adr_o), .tout_clr_i(tout_clr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic request(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    s_cyc_i = 1'b1;
    s_stb_i = 1'b1;
    s_we_i  = we;
    s_sel_i = 4'hF;
    s_adr_i = adr;
    s_dat_i = dat;
  endtask

  task automatic release_bus();
    s_cyc_i = 1'b0;
    s_stb_i = 1'b0;
    s_we_i  = 1'b0;
    ack_i   = '0;
  endtask

  initial begin
    rst_i = 1'b1; tout_clr_i = 1'b0;
    s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0; s_sel_i = '0;
    s_adr_i = '0; s_dat_i = '0; ack_i = '0; dat_i = '0;
    tick(2);
    check_output("rst_ack",   32'(s_ack_o),   32'd0);
    check_output("rst_stall", 32'(s_stall_o), 32'd0);
    check_output("rst_cs",    32'(cs_o),      32'd0);
    check_output("rst_dat",   s_dat_o,        32'd0);
    check_output("rst_tout",  32'(tout_o),    32'd0);
    rst_i = 1'b0;
    tick();

    // Read slot 3, device answers 4 cycles after chip-select
    request(1'b0, 32'hFD03_0010, 32'h0);
    tick();
    check_output("rd3_cs",    32'(cs_o),      32'h08);
    check_output("rd3_stall", 32'(s_stall_o), 32'd1);
    check_output("rd3_adr",   adr_o,          32'hFD03_0010);
    tick(3);
    check_output("rd3_noack", 32'(s_ack_o),   32'd0);
    dat_i[32*3 +: 32] = 32'h1234_5678;
    ack_i = 8'h08;
    tick();
    check_output("rd3_ack",   32'(s_ack_o),   32'd1);
    check_output("rd3_data",  s_dat_o,        32'h1234_5678);
    check_output("rd3_csoff", 32'(cs_o),      32'd0);
    ack_i = '0;
    tick();
    check_output("rd3_hold",  32'(s_ack_o),   32'd1);
    release_bus();
    tick();
    check_output("rd3_drop",  32'(s_ack_o),   32'd0);
    check_output("rd3_dat0",  s_dat_o,        32'd0);
    check_output("rd3_idle",  32'(s_stall_o), 32'd0);
    tick();

    // Write slot 5; device data must not leak back on a write
    request(1'b1, 32'hFD05_0004, 32'hA5A5_0001);
    tick();
    check_output("wr5_cs",  32'(cs_o),  32'h20);
    check_output("wr5_adr", adr_o,      32'hFD05_0004);
    check_output("wr5_dat", dat_o,      32'hA5A5_0001);
    check_output("wr5_sel", 32'(sel_o), 32'hF);
    check_output("wr5_we",  32'(we_o),  32'd1);
    dat_i[32*5 +: 32] = 32'hDEAD_BEEF;
    ack_i = 8'h20;
    tick();
    check_output("wr5_ack",  32'(s_ack_o), 32'd1);
    check_output("wr5_rdat", s_dat_o,      32'd0);
    check_output("wr5_weoff", 32'(we_o),   32'd0);
    release_bus();
    tick();
    check_output("wr5_drop", 32'(s_ack_o), 32'd0);
    tick();

    // Timeout on unpopulated slot 7
    request(1'b0, 32'hFD07_0000, 32'h0);
    tick();
    check_output("to7_cs", 32'(cs_o), 32'h80);
    tick(15);
    check_output("to7_early", 32'(s_ack_o), 32'd0);
    check_output("to7_tout0", 32'(tout_o),  32'd0);
    tick();
    check_output("to7_ack",  32'(s_ack_o),  32'd1);
    check_output("to7_data", s_dat_o,       32'hFFFF_FFFF);
    check_output("to7_tout", 32'(tout_o),   32'd1);
    check_output("to7_tadr", tout_adr_o,    32'hFD07_0000);
    check_output("to7_cs0",  32'(cs_o),     32'd0);
    release_bus();
    tout_clr_i = 1'b1;
    tick();
    tout_clr_i = 1'b0;
    check_output("to7_clr",   32'(tout_o),  32'd0);
    check_output("to7_tadrk", tout_adr_o,   32'hFD07_0000);
    check_output("to7_drop",  32'(s_ack_o), 32'd0);
    tick();

    // Abort two cycles into WAIT
    request(1'b0, 32'hFD01_0000, 32'h0);
    tick(3);
    release_bus();
    tick();
    check_output("ab_cs",    32'(cs_o),      32'd0);
    check_output("ab_stall", 32'(s_stall_o), 32'd0);
    check_output("ab_ack",   32'(s_ack_o),   32'd0);
    tick();
    check_output("ab_ack2",  32'(s_ack_o),   32'd0);

    // Ack from a non-selected device is ignored
    request(1'b0, 32'hFD02_0000, 32'h0);
    tick();
    check_output("wd_cs", 32'(cs_o), 32'h04);
    ack_i = 8'h10;
    dat_i[32*4 +: 32] = 32'h4444_4444;
    tick();
    check_output("wd_ign",   32'(s_ack_o),   32'd0);
    check_output("wd_wait",  32'(s_stall_o), 32'd1);
    check_output("wd_cskep", 32'(cs_o),      32'h04);
    ack_i = 8'h04;
    dat_i[32*2 +: 32] = 32'hCAFE_0002;
    tick();
    check_output("wd_ack",  32'(s_ack_o), 32'd1);
    check_output("wd_data", s_dat_o,      32'hCAFE_0002);
    release_bus();
    tick(2);

    // Device ack on the timeout cycle beats the timeout
    request(1'b0, 32'hFD06_0000, 32'h0);
    tick(16);
    check_output("sim_early", 32'(s_ack_o), 32'd0);
    ack_i = 8'h40;
    dat_i[32*6 +: 32] = 32'h600D_0006;
    tick();
    check_output("sim_ack",  32'(s_ack_o), 32'd1);
    check_output("sim_data", s_dat_o,      32'h600D_0006);
    check_output("sim_tout", 32'(tout_o),  32'd0);
    release_bus();
    tick(2);

    // Reset in the middle of a WAIT
    request(1'b1, 32'hFD04_0008, 32'h1111_2222);
    tick();
    check_output("rw_cs", 32'(cs_o), 32'h10);
    tick();
    rst_i = 1'b1;
    tick();
    check_output("rw_cs0",    32'(cs_o),      32'd0);
    check_output("rw_we0",    32'(we_o),      32'd0);
    check_output("rw_stall0", 32'(s_stall_o), 32'd0);
    check_output("rw_ack0",   32'(s_ack_o),   32'd0);
    check_output("rw_adr0",   adr_o,          32'd0);
    check_output("rw_tadr0",  tout_adr_o,     32'd0);
    rst_i = 1'b0;
    release_bus();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
